// File: rtl/uart_tx_arbiter.sv
// Message-locked arbiter sharing one uart_tx byte transmitter among N_REQ sources.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              ack,
  output logic [N_REQ-1:0]              grant,
  output logic                          active,
  output logic [15:0]                   byte_cnt,
  input  logic                          uart_tx_busy,
  output logic                          uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]       uart_tx_data
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [IW-1:0]           pick_idx;
  logic                    pick_valid;
  logic [PAYLOAD_BITS-1:0] data_q;
  logic                    last_q;
  logic [PAYLOAD_BITS-1:0] slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr, ptr_nxt;

  // Scan downward from the farthest candidate so the one nearest the pointer wins.
  always_comb begin
    logic [IW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end
`endif

  // NOTE: every output of a combinational block gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    ack        = '0;
    uart_tx_en = 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
    ptr_nxt    = ptr;
`endif
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          idx_nxt   = pick_idx;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req[idx]) begin
          ack[idx]  = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (!uart_tx_busy) begin
          uart_tx_en = 1'b1;
          state_nxt  = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            state_nxt = S_IDLE;
`ifndef UART_ARB_FIXED_PRIO_EN
            ptr_nxt   = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
`endif
          end else begin
            state_nxt = S_LOAD;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      idx      <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      byte_cnt <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr   <= ptr_nxt;
`endif
      if (state == S_IDLE && pick_valid) begin
        byte_cnt <= '0;
      end else if (uart_tx_en && byte_cnt != 16'hFFFF) begin
        byte_cnt <= byte_cnt + 16'd1;
      end
      if (|ack) begin
        data_q <= slice[idx];
        last_q <= req_last[idx];
      end
    end
  end

  assign grant        = (state == S_IDLE) ? '0 : ({{(N_REQ-1){1'b0}}, 1'b1} << idx);
  assign active       = (state != S_IDLE);
  assign uart_tx_data = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: message-level scoreboard plus directed scenarios.
// Honours UART_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int FRAME = 4;
  localparam int DEPTH = 64;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack, grant;
  logic           active;
  logic [15:0]    byte_cnt;
  logic           uart_tx_busy = 1'b0;
  logic           uart_tx_en;
  logic [W-1:0]   uart_tx_data;

  uart_tx_arbiter #(.N_REQ(N), .PAYLOAD_BITS(W)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .active(active), .byte_cnt(byte_cnt),
    .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sources: each holds a byte queue of {last, data}; ack pops the head.
  logic [W:0]   src_mem [N][DEPTH];
  int           src_head [N];
  int           src_tail [N];
  int           stall_cnt [N];
  int           stall_len [N];
  logic [N-1:0] force_req = '0;
  logic [N-1:0] ack_seen  = '0;

  task automatic push_msg(input int s, input int len, input logic [31:0] bytes);
    for (int k = 0; k < len; k++) begin
      src_mem[s][src_tail[s]] = {(k == len - 1), bytes[8*(len-1-k) +: 8]};
      src_tail[s]++;
    end
  endtask

  // Scoreboard state.
  int           model_owner = -1;
  int           model_ptr   = 0;
  int           msg_cnt     = 0;
  bit           last_sent   = 1'b0;
  int           exp_idx [N];
  logic [N-1:0] prev_req   = '0;
  logic [N-1:0] prev_grant = '0;
  bit           started    = 1'b0;
  bit           uart_pend  = 1'b0;
  int           uart_cnt   = 0;
  bit           hold_valid = 1'b0;
  logic [W-1:0] hold_data  = '0;
  int           en_total   = 0;
  logic [W-1:0] en_log_data [$];
  int           onset_log [$];
  int           done_owner [$];
  int           done_cnt [$];

  task automatic flush_sources();
    for (int s = 0; s < N; s++) begin
      src_head[s]  = src_tail[s];
      exp_idx[s]   = src_tail[s];
      stall_cnt[s] = 0;
      stall_len[s] = 0;
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (ack_seen[s]) begin
          src_head[s]++;
          if (stall_len[s] != 0) begin
            stall_cnt[s] = stall_len[s];
            stall_len[s] = 0;
          end
        end else if (stall_cnt[s] > 0) begin
          stall_cnt[s]--;
        end
        req[s] = force_req[s] || (src_head[s] < src_tail[s] && stall_cnt[s] == 0);
        req_data[s*W +: W] = (src_head[s] < src_tail[s]) ? src_mem[s][src_head[s]][W-1:0] : '0;
        req_last[s] = (src_head[s] < src_tail[s]) ? src_mem[s][src_head[s]][W] : 1'b0;
      end
      ack_seen = '0;
    end
  end

  initial begin : monitor
    int w;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_active", active, 0);
        check("rst_en", uart_tx_en, 0);
        check("rst_byte_cnt", byte_cnt, 0);
        check("rst_data", uart_tx_data, 0);
        model_owner = -1;
        model_ptr   = 0;
        msg_cnt     = 0;
        last_sent   = 1'b0;
        hold_valid  = 1'b0;
        started     = 1'b1;
        ack_seen    = '0;
      end else if (started) begin
        if (prev_grant == '0) begin
          if (prev_req == '0) begin
            check("idle_no_grant", grant, 0);
          end else begin
            w = pick(prev_req, model_ptr);
            check("grant_pick", grant, 32'(1) << w);
            model_owner = w;
            msg_cnt     = 0;
            last_sent   = 1'b0;
            onset_log.push_back(w);
          end
        end else if (grant == '0) begin
          check("end_on_last", last_sent, 1);
          done_owner.push_back(model_owner);
          done_cnt.push_back(msg_cnt);
`ifdef UART_ARB_FIXED_PRIO_EN
          model_ptr = 0;
`else
          model_ptr = (model_owner + 1) % N;
`endif
          model_owner = -1;
        end else begin
          check("grant_locked", grant, prev_grant);
        end
        check("active", active, grant != '0);
        check("byte_cnt", byte_cnt, msg_cnt);
        check("ack_onehot", $onehot0(ack), 1);
        check("ack_granted", ack & ~grant, 0);
        check("ack_req", ack & ~req, 0);
        ack_seen = ack;
        if (uart_tx_en) begin
          check("en_granted", grant != '0, 1);
          check("en_after_last", last_sent, 0);
          check("en_uart_idle", uart_tx_busy | uart_pend, 0);
          if (model_owner >= 0) begin
            check("tx_data", uart_tx_data, src_mem[model_owner][exp_idx[model_owner]][W-1:0]);
            last_sent = src_mem[model_owner][exp_idx[model_owner]][W];
            exp_idx[model_owner]++;
          end
          if (msg_cnt < 65535) msg_cnt++;
          en_log_data.push_back(uart_tx_data);
          en_total++;
          hold_valid = 1'b1;
          hold_data  = uart_tx_data;
        end else if (hold_valid && (uart_pend || uart_tx_busy)) begin
          check("data_stable", uart_tx_data, hold_data);
        end
      end
      // uart_tx stand-in: busy rises one cycle after en and lasts FRAME cycles.
      if (uart_tx_en && !uart_pend && !uart_tx_busy) begin
        uart_pend = 1'b1;
      end else if (uart_pend) begin
        uart_pend    = 1'b0;
        uart_tx_busy = 1'b1;
        uart_cnt     = FRAME;
      end else if (uart_tx_busy) begin
        uart_cnt--;
        if (uart_cnt == 0) uart_tx_busy = 1'b0;
      end
      prev_req   = req;
      prev_grant = grant;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    flush_sources();
    repeat (2) tick();
    resetn = 1'b1;
    tick();
  endtask

  function automatic bit all_quiet();
    for (int s = 0; s < N; s++) if (src_head[s] != src_tail[s] || stall_cnt[s] != 0) return 1'b0;
    return (grant == '0) && !uart_tx_busy && !uart_pend;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int c = 0;
    while (c < budget && !all_quiet()) begin
      tick();
      c++;
    end
    check({name, "_timeout"}, c < budget, 1);
  endtask

  task automatic wait_en(input int target, input int budget, input string name);
    int c = 0;
    while (c < budget && en_total < target) begin
      tick();
      c++;
    end
    check({name, "_timeout"}, c < budget, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int            b;
    int            c;
    logic [31:0]   neo;
    int            exp_order [5];
    int            exp_rr2 [4];

    for (int s = 0; s < N; s++) begin
      src_head[s]  = 0;
      src_tail[s]  = 0;
      stall_cnt[s] = 0;
      stall_len[s] = 0;
      exp_idx[s]   = 0;
    end

    // Reset with every request asserted.
    force_req = '1;
    repeat (3) tick();
    check("t1_grant", grant, 0);
    check("t1_ack", ack, 0);
    check("t1_en", uart_tx_en, 0);
    check("t1_byte_cnt", byte_cnt, 0);
    force_req = '0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    // Single source sends "Neo.".
    neo = 32'h4E656F2E;
    b = en_log_data.size();
    push_msg(0, 4, neo);
    wait_done(400, "t2");
    check("t2_en_count", en_log_data.size() - b, 4);
    for (int k = 0; k < 4; k++) check("t2_byte", en_log_data[b + k], neo[8*(3-k) +: 8]);
    check("t2_byte_cnt", byte_cnt, 4);
    check("t2_grant_idle", grant, 0);

    // Contention between sources 1 and 2.
    reset_dut();
    b = onset_log.size();
    c = en_log_data.size();
    push_msg(1, 2, 32'hA1A2);
    push_msg(2, 2, 32'hB1B2);
    wait_done(400, "t3");
    check("t3_first", onset_log[b], 1);
    check("t3_second", onset_log[b + 1], 2);
    check("t3_byte2", en_log_data[c + 2], 8'hB1);

    // Sources 1 and 3 each queue two single-byte messages.
    reset_dut();
    b = onset_log.size();
    push_msg(1, 1, 32'hC1);
    push_msg(1, 1, 32'hC2);
    push_msg(3, 1, 32'hD1);
    push_msg(3, 1, 32'hD2);
    wait_done(400, "t3b");
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_rr2 = '{1, 1, 3, 3};
`else
    exp_rr2 = '{1, 3, 1, 3};
`endif
    for (int k = 0; k < 4; k++) check("t3b_order", onset_log[b + k], exp_rr2[k]);

    // All four requesting; source 0 has a second message.
    reset_dut();
    b = onset_log.size();
    push_msg(0, 1, 32'h10);
    push_msg(0, 1, 32'h11);
    push_msg(1, 1, 32'h20);
    push_msg(2, 1, 32'h30);
    push_msg(3, 1, 32'h40);
    wait_done(600, "t4");
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    for (int k = 0; k < 5; k++) check("t4_order", onset_log[b + k], exp_order[k]);

    // Source 2 stalls 50 cycles after its first byte while source 0 waits.
    reset_dut();
    b = done_owner.size();
    stall_len[2] = 50;
    push_msg(2, 3, 32'h112233);
    c = 0;
    while (c < 100 && stall_cnt[2] == 0) begin
      tick();
      c++;
    end
    check("t5_stall_timeout", c < 100, 1);
    push_msg(0, 1, 32'h44);
    repeat (5) tick();
    c = en_total;
    repeat (35) tick();
    check("t5_no_en", en_total, c);
    check("t5_grant", grant, 4'b0100);
    check("t5_no_ack", ack, 0);
    wait_done(600, "t5");
    check("t5_owner", done_owner[b], 2);
    check("t5_cnt", done_cnt[b], 3);
    check("t5_next", done_owner[b + 1], 0);

    // Reset while byte 2 of a message is on the line.
    reset_dut();
    push_msg(1, 3, 32'h515253);
    wait_en(en_total + 2, 200, "t6_en2");
    c = 0;
    while (c < 20 && !uart_tx_busy) begin
      tick();
      c++;
    end
    check("t6_busy_timeout", c < 20, 1);
    tick();
    resetn = 1'b0;
    flush_sources();
    tick();
    check("t6_grant", grant, 0);
    check("t6_active", active, 0);
    check("t6_byte_cnt", byte_cnt, 0);
    check("t6_data", uart_tx_data, 0);
    resetn = 1'b1;
    b = onset_log.size();
    push_msg(3, 2, 32'h6162);
    wait_en(en_total + 1, 200, "t6_en1");
    tick();
    check("t6_restart_cnt", byte_cnt, 1);
    wait_done(400, "t6");
    check("t6_owner", onset_log[b], 3);
    check("t6_final_cnt", byte_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
